// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
package alu_pkg;

  localparam int ALU_W = 32;

  // ALU operation encodings as seen on the sel lines (11 is also add).
  typedef enum logic [1:0] {
    ADD   = 2'b00,
    SUB   = 2'b01,
    PASSB = 2'b10
  } alu_op_t;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. Purely combinational; on a tie the
// requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; tie broken away from last_grant.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one execute-stage ALU between the main execute path (r0) and
// the auxiliary compare unit (r1). Operands are registered toward the
// ALU, the result and flags are registered back and returned to the
// requester that owns the transaction.
//
// state | meaning
// IDLE  | waiting; req_ready offered to the round-robin winner
// EXEC  | ALU evaluates registered operands; result captured at edge
// RESP  | result held for the owner until its resp_ready
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [1:0]       r0_sel,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,

  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [1:0]       r1_sel,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,

  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_neg,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  arb_state_t       state;
  logic             last_grant;
  logic             owner;
  logic [1:0]       grant;
  logic             accept;
  logic             owner_taken;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [1:0]       win_sel;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      ({r1_req_valid, r0_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is offered only in IDLE and never while reset is held, so a
  // requester cannot believe it was accepted on a reset cycle.
  assign r0_req_ready = rst_n && (state == IDLE) && grant[0];
  assign r1_req_ready = rst_n && (state == IDLE) && grant[1];
  assign accept       = r0_req_ready || r1_req_ready;

  // Operand mux for the winning requester.
  always_comb begin
    win_a   = r0_a;
    win_b   = r0_b;
    win_sel = r0_sel;
    if (grant[1]) begin
      win_a   = r1_a;
      win_b   = r1_b;
      win_sel = r1_sel;
    end
  end

  // Response handshake from whichever requester owns the result.
  assign owner_taken = owner ? r1_resp_ready : r0_resp_ready;

  // Sequencer: operand capture, result capture and response hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= ADD;
      resp_data     <= '0;
      resp_zero     <= 1'b0;
      resp_neg      <= 1'b0;
      r0_resp_valid <= 1'b0;
      r1_resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // sel is forwarded untouched; the ALU decides what 11 means.
            alu_a   <= win_a;
            alu_b   <= win_b;
            alu_sel <= win_sel;
            owner   <= grant[1];
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_data     <= alu_out;
          resp_zero     <= alu_zero;
          resp_neg      <= alu_out[WIDTH-1];
          r0_resp_valid <= !owner;
          r1_resp_valid <= owner;
          state         <= RESP;
        end
        RESP: begin
          if (owner_taken) begin
            last_grant    <= owner;
            r0_resp_valid <= 1'b0;
            r1_resp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          r0_resp_valid <= 1'b0;
          r1_resp_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU
// attached to the alu_* ports and a response scoreboard.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
  logic [31:0] r0_a, r0_b;
  logic [1:0]  r0_sel;
  logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
  logic [31:0] r1_a, r1_b;
  logic [1:0]  r1_sel;
  logic [31:0] resp_data;
  logic        resp_zero, resp_neg;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        alu_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [31:0] exp_data;
    bit          exp_zero;
    bit          exp_neg;
  } vec_t;

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          zero;
    bit          neg;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .r0_req_valid  (r0_req_valid),
    .r0_req_ready  (r0_req_ready),
    .r0_a          (r0_a),
    .r0_b          (r0_b),
    .r0_sel        (r0_sel),
    .r0_resp_valid (r0_resp_valid),
    .r0_resp_ready (r0_resp_ready),
    .r1_req_valid  (r1_req_valid),
    .r1_req_ready  (r1_req_ready),
    .r1_a          (r1_a),
    .r1_b          (r1_b),
    .r1_sel        (r1_sel),
    .r1_resp_valid (r1_resp_valid),
    .r1_resp_ready (r1_resp_ready),
    .resp_data     (resp_data),
    .resp_zero     (resp_zero),
    .resp_neg      (resp_neg),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_sel       (alu_sel),
    .alu_out       (alu_out),
    .alu_zero      (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 00 add, 01 sub, 10 pass B, 11 add.
  always_comb begin
    case (alu_sel)
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_b;
      default: alu_out = alu_a + alu_b;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit id, input bit v, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] sel);
    if (id) begin
      r1_req_valid = v; r1_a = a; r1_b = b; r1_sel = sel;
    end else begin
      r0_req_valid = v; r0_a = a; r0_b = b; r0_sel = sel;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("resp_valid_exclusive", {31'd0, r0_resp_valid & r1_resp_valid}, 32'd0);
      if ((r0_resp_valid && r0_resp_ready) || (r1_resp_valid && r1_resp_ready)) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("resp_owner", {31'd0, r1_resp_valid}, {31'd0, e.id});
          chk("resp_data", resp_data, e.data);
          chk("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
          chk("resp_neg", {31'd0, resp_neg}, {31'd0, e.neg});
        end
      end
    end
  end

  // One isolated transaction with cycle-exact latency checks.
  task automatic run_vec(input vec_t v);
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    drive(v.id, 1'b1, v.a, v.b, v.sel);
    #1;
    chk("req_ready_T", {31'd0, v.id ? r1_req_ready : r0_req_ready}, 32'd1);
    chk("other_ready_T", {31'd0, v.id ? r0_req_ready : r1_req_ready}, 32'd0);
    sb.push_back('{v.id, v.exp_data, v.exp_zero, v.exp_neg});
    step();
    drive(v.id, 1'b0, 32'd0, 32'd0, 2'b00);
    chk("alu_a_T1", alu_a, v.a);
    chk("alu_b_T1", alu_b, v.b);
    chk("alu_sel_T1", {30'd0, alu_sel}, {30'd0, v.sel});
    chk("no_resp_T1", {31'd0, r0_resp_valid | r1_resp_valid}, 32'd0);
    step();
    chk("own_resp_valid_T2", {31'd0, v.id ? r1_resp_valid : r0_resp_valid}, 32'd1);
    chk("other_resp_valid_T2", {31'd0, v.id ? r0_resp_valid : r1_resp_valid}, 32'd0);
    step();
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd5,          32'd3,  2'b00, 32'd8,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd7,          32'd7,  2'b01, 32'd0,          1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'd0,          32'd1,  2'b01, 32'hFFFF_FFFF,  1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'd9,          32'd42, 2'b10, 32'd42,         1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'd1,          32'd2,  2'b11, 32'd3,          1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'd0,  2'b00, 32'h8000_0000,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,  2'b00, 32'd0,          1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'd3,          32'd5,  2'b10, 32'd5,          1'b0, 1'b0};

    rst_n = 1'b0;
    r0_req_valid = 1'b1; r0_a = 32'd11; r0_b = 32'd22; r0_sel = 2'b01;
    r1_req_valid = 1'b0; r1_a = 32'd0;  r1_b = 32'd0;  r1_sel = 2'b00;
    r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;

    // Reset state, including no acceptance while reset is held.
    repeat (3) step();
    chk("rst_r0_req_ready", {31'd0, r0_req_ready}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", {30'd0, alu_sel}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_flags", {30'd0, resp_zero, resp_neg}, 32'd0);
    chk("rst_resp_valid", {30'd0, r0_resp_valid, r1_resp_valid}, 32'd0);
    r0_req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_no_valid_ready", {30'd0, r0_req_ready, r1_req_ready}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Tie after reset: r0 first, then strict alternation.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    drive(1'b0, 1'b1, 32'd10,  32'd4,  2'b01);
    drive(1'b1, 1'b1, 32'd100, 32'd23, 2'b00);
    for (int k = 0; k < 4; k++) begin
      bit exp_id;
      exp_id = k[0];
      #1;
      chk("tie_winner_ready", {31'd0, exp_id ? r1_req_ready : r0_req_ready}, 32'd1);
      chk("tie_loser_ready", {31'd0, exp_id ? r0_req_ready : r1_req_ready}, 32'd0);
      if (exp_id) sb.push_back('{1'b1, 32'd123, 1'b0, 1'b0});
      else        sb.push_back('{1'b0, 32'd6,   1'b0, 1'b0});
      step();
      chk("exec_no_ready", {30'd0, r0_req_ready, r1_req_ready}, 32'd0);
      step();
      step();
    end
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;

    // Backpressure: r0 owns the result and stalls; r1 waits then wins.
    r0_resp_ready = 1'b0;
    drive(1'b0, 1'b1, 32'd20, 32'd30, 2'b00);
    drive(1'b1, 1'b1, 32'd2,  32'd3,  2'b10);
    #1;
    chk("bp_r0_granted", {31'd0, r0_req_ready}, 32'd1);
    sb.push_back('{1'b0, 32'd50, 1'b0, 1'b0});
    step();
    r0_req_valid = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid_held", {31'd0, r0_resp_valid}, 32'd1);
      chk("bp_resp_data_held", resp_data, 32'd50);
      chk("bp_flags_held", {30'd0, resp_zero, resp_neg}, 32'd0);
      chk("bp_r1_not_ready", {31'd0, r1_req_ready}, 32'd0);
      step();
    end
    r0_resp_ready = 1'b1;
    sb.push_back('{1'b1, 32'd3, 1'b0, 1'b0});
    step();
    chk("bp_r1_granted_next", {31'd0, r1_req_ready}, 32'd1);
    step();
    r1_req_valid = 1'b0;
    step();
    step();

    // Reset while in EXEC drops the transaction silently.
    drive(1'b0, 1'b1, 32'd1, 32'd1, 2'b00);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    rst_n = 1'b0;
    step();
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    chk("midrst_resp_valid", {30'd0, r0_resp_valid, r1_resp_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_still_no_resp", {30'd0, r0_resp_valid, r1_resp_valid}, 32'd0);
    run_vec('{1'b1, 32'd12, 32'd5, 2'b01, 32'd7, 1'b0, 1'b0});

    repeat (2) step();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
